warp_fetch_scheduler: RTL and testbench

Per-warp fetch scheduler for the compute unit. Tracks the lifecycle and program counter of every warp slot and arbitrates fairly among eligible warps for the single fetcher port. It drives the fetcher handshake whose warp ID feeds the per-warp dispatchers. It consumes dispatcher backpressure through per-warp buffer-space and all-finished flags, and receives PC updates or stop requests from the decoder.

---
 rtl/warp_fetch_scheduler_if.sv | 55 +++++
 rtl/warp_fetch_scheduler.sv | 153 +++++++++++++++
 tb/tb_warp_fetch_scheduler.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/warp_fetch_scheduler_if.sv
// Handshake bundle between the warp fetch scheduler and its start, fetch,
// dispatcher and decoder neighbours.
interface warp_fetch_scheduler_if #(
  parameter int unsigned NumWarps   = 8,
  parameter int unsigned PcWidth    = 32,
  parameter int unsigned WarpWidth  = 32,
  parameter int unsigned FetchWidth = 1
);
  localparam int unsigned WidWidth = (NumWarps > 1) ? $clog2(NumWarps) : 1;

  logic                           start_valid_i;
  logic                           start_ready_o;
  logic [PcWidth-1:0]             start_pc_i;
  logic [WarpWidth-1:0]           start_act_mask_i;
  logic [WidWidth-1:0]            start_wid_o;

  logic [NumWarps*FetchWidth-1:0] ib_space_available_i;
  logic [NumWarps-1:0]            ib_all_instr_finished_i;

  logic                           fe_ready_i;
  logic                           fe_valid_o;
  logic [WidWidth-1:0]            fe_warp_id_o;
  logic [PcWidth-1:0]             fe_pc_o;
  logic [WarpWidth-1:0]           fe_act_mask_o;

  logic                           dec_update_valid_i;
  logic [WidWidth-1:0]            dec_update_wid_i;
  logic [PcWidth-1:0]             dec_update_pc_i;
  logic                           dec_update_stop_i;

  logic                           warp_done_o;
  logic [WidWidth-1:0]            warp_done_wid_o;

  // Scheduler side.
  modport master (
    input  start_valid_i, start_pc_i, start_act_mask_i,
    input  ib_space_available_i, ib_all_instr_finished_i,
    input  fe_ready_i,
    input  dec_update_valid_i, dec_update_wid_i, dec_update_pc_i, dec_update_stop_i,
    output start_ready_o, start_wid_o,
    output fe_valid_o, fe_warp_id_o, fe_pc_o, fe_act_mask_o,
    output warp_done_o, warp_done_wid_o
  );

  // Environment side (launcher, fetcher, dispatchers, decoder).
  modport slave (
    output start_valid_i, start_pc_i, start_act_mask_i,
    output ib_space_available_i, ib_all_instr_finished_i,
    output fe_ready_i,
    output dec_update_valid_i, dec_update_wid_i, dec_update_pc_i, dec_update_stop_i,
    input  start_ready_o, start_wid_o,
    input  fe_valid_o, fe_warp_id_o, fe_pc_o, fe_act_mask_o,
    input  warp_done_o, warp_done_wid_o
  );
endinterface

// File: rtl/warp_fetch_scheduler.sv
// Per-warp lifecycle/PC tracking with round-robin arbitration of eligible
// warps onto the single fetcher port.
module warp_fetch_scheduler #(
  parameter int unsigned NumWarps   = 8,
  parameter int unsigned PcWidth    = 32,
  parameter int unsigned WarpWidth  = 32,
  parameter int unsigned FetchWidth = 1
) (
  input logic                   clk_i,
  input logic                   rst_ni,
  warp_fetch_scheduler_if.master bus
);
  localparam int unsigned WidWidth = (NumWarps > 1) ? $clog2(NumWarps) : 1;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    READY    = 2'd1,
    WAIT_DEC = 2'd2,
    DRAIN    = 2'd3
  } warp_state_e;

  warp_state_e          state_q [NumWarps];
  warp_state_e          state_d [NumWarps];
  logic [PcWidth-1:0]   pc_q    [NumWarps];
  logic [PcWidth-1:0]   pc_d    [NumWarps];
  logic [WarpWidth-1:0] mask_q  [NumWarps];
  logic [WarpWidth-1:0] mask_d  [NumWarps];
  logic [WidWidth-1:0]  rr_ptr_q, rr_ptr_d;
  logic                 done_q, done_d;
  logic [WidWidth-1:0]  done_wid_q, done_wid_d;

  logic [NumWarps-1:0]  idle_c, eligible_c, retire_req_c;
  logic [WidWidth-1:0]  start_wid_c, retire_wid_c, win_wid_c;
  logic                 win_valid_c;
  logic [WidWidth:0]    cand_c;
  logic                 start_fire_c, fe_fire_c;

  // Per-warp status vectors and lowest-index pickers for start and retire.
  always_comb begin
    idle_c       = '0;
    eligible_c   = '0;
    retire_req_c = '0;
    start_wid_c  = '0;
    retire_wid_c = '0;
    for (int unsigned w = 0; w < NumWarps; w++) begin
      idle_c[w]       = (state_q[w] == IDLE);
      eligible_c[w]   = (state_q[w] == READY) && bus.ib_space_available_i[w*FetchWidth];
      retire_req_c[w] = (state_q[w] == DRAIN) && bus.ib_all_instr_finished_i[w];
    end
    for (int i = int'(NumWarps) - 1; i >= 0; i--) begin
      if (idle_c[i])       start_wid_c  = WidWidth'(i);
      if (retire_req_c[i]) retire_wid_c = WidWidth'(i);
    end
  end

  // Round-robin search starting at rr_ptr, wrapping modulo NumWarps.
  always_comb begin
    win_valid_c = 1'b0;
    win_wid_c   = '0;
    cand_c      = '0;
    for (int unsigned i = 0; i < NumWarps; i++) begin
      cand_c = {1'b0, rr_ptr_q} + (WidWidth+1)'(i);
      if (cand_c >= (WidWidth+1)'(NumWarps)) cand_c = cand_c - (WidWidth+1)'(NumWarps);
      if (!win_valid_c && eligible_c[cand_c[WidWidth-1:0]]) begin
        win_valid_c = 1'b1;
        win_wid_c   = cand_c[WidWidth-1:0];
      end
    end
  end

  assign start_fire_c = bus.start_valid_i && (|idle_c);
  assign fe_fire_c    = win_valid_c && bus.fe_ready_i;

  // Next-state for every warp slot plus arbiter pointer and retire pulse.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    mask_d     = mask_q;
    rr_ptr_d   = rr_ptr_q;
    done_d     = |retire_req_c;
    done_wid_d = retire_wid_c;

    if (fe_fire_c) begin
      rr_ptr_d = (win_wid_c == WidWidth'(NumWarps - 1)) ? '0 : win_wid_c + WidWidth'(1);
    end

    for (int unsigned w = 0; w < NumWarps; w++) begin
      case (state_q[w])
        IDLE: begin
          if (start_fire_c && (start_wid_c == WidWidth'(w))) begin
            state_d[w] = READY;
            pc_d[w]    = bus.start_pc_i;
            mask_d[w]  = bus.start_act_mask_i;
          end
        end
        READY: begin
          if (fe_fire_c && (win_wid_c == WidWidth'(w))) state_d[w] = WAIT_DEC;
        end
        WAIT_DEC: begin
          if (bus.dec_update_valid_i && (bus.dec_update_wid_i == WidWidth'(w))) begin
            if (bus.dec_update_stop_i) begin
              state_d[w] = DRAIN;
            end else begin
              state_d[w] = READY;
              pc_d[w]    = bus.dec_update_pc_i;
            end
          end
        end
        DRAIN: begin
          if (retire_req_c[w] && (retire_wid_c == WidWidth'(w))) state_d[w] = IDLE;
        end
        default: state_d[w] = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned w = 0; w < NumWarps; w++) begin
        state_q[w] <= IDLE;
        pc_q[w]    <= '0;
        mask_q[w]  <= '0;
      end
      rr_ptr_q   <= '0;
      done_q     <= 1'b0;
      done_wid_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      mask_q     <= mask_d;
      rr_ptr_q   <= rr_ptr_d;
      done_q     <= done_d;
      done_wid_q <= done_wid_d;
    end
  end

  // Fetch and start outputs depend only on state and buffer space.
  assign bus.start_ready_o   = |idle_c;
  assign bus.start_wid_o     = start_wid_c;
  assign bus.fe_valid_o      = win_valid_c;
  assign bus.fe_warp_id_o    = win_valid_c ? win_wid_c : '0;
  assign bus.fe_pc_o         = win_valid_c ? pc_q[win_wid_c] : '0;
  assign bus.fe_act_mask_o   = win_valid_c ? mask_q[win_wid_c] : '0;
  assign bus.warp_done_o     = done_q;
  assign bus.warp_done_wid_o = done_wid_q;

  // Decoder updates must target a warp that is waiting on the decoder.
  a_dec_update_target: assert property (
    @(posedge clk_i) disable iff (!rst_ni)
    bus.dec_update_valid_i |->
      ((32'(bus.dec_update_wid_i) < NumWarps) && (state_q[bus.dec_update_wid_i] == WAIT_DEC))
  );
endmodule

// File: tb/tb_warp_fetch_scheduler.sv
// Scoreboard bench for warp_fetch_scheduler: expected grants/retires are
// queued with the stimulus and popped as the DUT produces them.
module tb_warp_fetch_scheduler;
  localparam int unsigned NumWarps  = 8;
  localparam int unsigned PcWidth   = 32;
  localparam int unsigned WarpWidth = 32;

  typedef struct packed {
    logic [2:0]  wid;
    logic [31:0] pc;
    logic [31:0] mask;
  } grant_t;

  logic clk;
  logic rst_n;
  int   n_checks = 0;
  int   n_errors = 0;

  grant_t     exp_q[$];
  logic [2:0] exp_done[$];
  logic       chk_grants = 1'b1;
  logic [7:0] stop_mask  = 8'h00;
  logic       grant_pend = 1'b0;
  logic [2:0] grant_wid  = '0;
  logic [31:0] grant_pc  = '0;

  warp_fetch_scheduler_if #(.NumWarps(NumWarps), .PcWidth(PcWidth),
                            .WarpWidth(WarpWidth), .FetchWidth(1)) bus ();

  warp_fetch_scheduler #(.NumWarps(NumWarps), .PcWidth(PcWidth),
                         .WarpWidth(WarpWidth), .FetchWidth(1)) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus.master)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] mask_of(input int w);
    return 32'hA5A5_0000 | 32'(w);
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_grant(input int w, input logic [31:0] pc, input logic [31:0] mask);
    grant_t g;
    g.wid  = 3'(w);
    g.pc   = pc;
    g.mask = mask;
    exp_q.push_back(g);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_fe_valid"},    64'(bus.fe_valid_o), 64'd0);
    check_eq({tag, "_fe_wid"},      64'(bus.fe_warp_id_o), 64'd0);
    check_eq({tag, "_fe_pc"},       64'(bus.fe_pc_o), 64'd0);
    check_eq({tag, "_start_ready"}, 64'(bus.start_ready_o), 64'd1);
    check_eq({tag, "_start_wid"},   64'(bus.start_wid_o), 64'd0);
    check_eq({tag, "_done"},        64'(bus.warp_done_o), 64'd0);
    check_eq({tag, "_done_wid"},    64'(bus.warp_done_wid_o), 64'd0);
  endtask

  // Monitor: compare every fetch handshake and retire pulse to the queues.
  initial forever begin
    grant_t g;
    logic [2:0] ed;
    @(negedge clk);
    if (bus.warp_done_o) begin
      check_eq("done_expected", 64'(exp_done.size() != 0), 64'd1);
      if (exp_done.size() != 0) begin
        ed = exp_done.pop_front();
        check_eq("done_wid", 64'(bus.warp_done_wid_o), 64'(ed));
      end
    end
    grant_pend = rst_n && bus.fe_valid_o && bus.fe_ready_i;
    if (grant_pend) begin
      grant_wid = bus.fe_warp_id_o;
      grant_pc  = bus.fe_pc_o;
      if (chk_grants) begin
        check_eq("grant_expected", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          g = exp_q.pop_front();
          check_eq("grant_wid",  64'(bus.fe_warp_id_o), 64'(g.wid));
          check_eq("grant_pc",   64'(bus.fe_pc_o), 64'(g.pc));
          check_eq("grant_mask", 64'(bus.fe_act_mask_o), 64'(g.mask));
        end
      end
    end
  end

  // Decoder model: answers each handshake one cycle later with pc+0x10.
  initial forever begin
    @(posedge clk);
    #1;
    if (grant_pend && rst_n) begin
      bus.dec_update_valid_i = 1'b1;
      bus.dec_update_wid_i   = grant_wid;
      bus.dec_update_pc_i    = grant_pc + 32'h10;
      bus.dec_update_stop_i  = stop_mask[grant_wid];
    end else begin
      bus.dec_update_valid_i = 1'b0;
      bus.dec_update_wid_i   = '0;
      bus.dec_update_pc_i    = '0;
      bus.dec_update_stop_i  = 1'b0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n                       = 1'b0;
    bus.start_valid_i           = 1'b0;
    bus.start_pc_i              = '0;
    bus.start_act_mask_i        = '0;
    bus.ib_space_available_i    = 8'hFF;
    bus.ib_all_instr_finished_i = 8'h00;
    bus.fe_ready_i              = 1'b0;
    bus.dec_update_valid_i      = 1'b0;
    bus.dec_update_wid_i        = '0;
    bus.dec_update_pc_i         = '0;
    bus.dec_update_stop_i       = 1'b0;

    repeat (2) @(negedge clk);
    check_reset_outputs("rst");
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Launch all eight warps; fetcher held off.
    for (int w = 0; w < 8; w++) begin
      bus.start_valid_i    = 1'b1;
      bus.start_pc_i       = 32'((w + 1) * 256);
      bus.start_act_mask_i = mask_of(w);
      @(negedge clk);
      check_eq("start_ready", 64'(bus.start_ready_o), 64'd1);
      check_eq("start_wid", 64'(bus.start_wid_o), 64'(w));
      if (w == 0) check_eq("fe_valid_before_start", 64'(bus.fe_valid_o), 64'd0);
      if (w == 1) begin
        check_eq("first_fe_valid", 64'(bus.fe_valid_o), 64'd1);
        check_eq("first_fe_wid",   64'(bus.fe_warp_id_o), 64'd0);
        check_eq("first_fe_pc",    64'(bus.fe_pc_o), 64'h100);
        check_eq("first_fe_mask",  64'(bus.fe_act_mask_o), 64'(mask_of(0)));
      end
      @(posedge clk);
      #1;
    end
    bus.start_valid_i = 1'b0;
    @(negedge clk);
    check_eq("full_start_ready", 64'(bus.start_ready_o), 64'd0);
    check_eq("full_start_wid",   64'(bus.start_wid_o), 64'd0);

    // Stall: request must hold steady while fe_ready is low.
    repeat (5) begin
      @(negedge clk);
      check_eq("stall_valid", 64'(bus.fe_valid_o), 64'd1);
      check_eq("stall_wid",   64'(bus.fe_warp_id_o), 64'd0);
      check_eq("stall_pc",    64'(bus.fe_pc_o), 64'h100);
    end
    @(posedge clk);
    #1;

    // Fairness: two full rounds, 0..7 twice, PC advancing by 0x10 per round.
    for (int r = 0; r < 2; r++)
      for (int w = 0; w < 8; w++)
        push_grant(w, 32'((w + 1) * 256 + r * 16), mask_of(w));
    bus.fe_ready_i = 1'b1;
    tick(16);
    bus.fe_ready_i = 1'b0;
    tick(2);
    check_eq("fair_all_granted", 64'(exp_q.size()), 64'd0);

    // Warp 3 without buffer space is skipped until its space returns.
    bus.ib_space_available_i = 8'h14;
    push_grant(2, 32'h320, mask_of(2));
    push_grant(4, 32'h520, mask_of(4));
    push_grant(2, 32'h330, mask_of(2));
    bus.fe_ready_i = 1'b1;
    tick(3);
    bus.ib_space_available_i = 8'h1C;
    push_grant(3, 32'h420, mask_of(3));
    push_grant(4, 32'h530, mask_of(4));
    tick(2);
    bus.fe_ready_i = 1'b0;
    tick(2);
    check_eq("space_all_granted", 64'(exp_q.size()), 64'd0);

    // Warp 1 stops and drains for four cycles before retiring.
    bus.ib_space_available_i = 8'h02;
    stop_mask = 8'h02;
    push_grant(1, 32'h220, mask_of(1));
    bus.fe_ready_i = 1'b1;
    tick(1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_eq("drain_no_fetch", 64'(bus.fe_valid_o), 64'd0);
      check_eq("drain_no_done",  64'(bus.warp_done_o), 64'd0);
      @(posedge clk);
      #1;
    end
    bus.ib_all_instr_finished_i = 8'h02;
    exp_done.push_back(3'd1);
    @(negedge clk);
    check_eq("done_not_early", 64'(bus.warp_done_o), 64'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    check_eq("retire_done",        64'(bus.warp_done_o), 64'd1);
    check_eq("retire_done_wid",    64'(bus.warp_done_wid_o), 64'd1);
    check_eq("retire_start_ready", 64'(bus.start_ready_o), 64'd1);
    check_eq("retire_start_wid",   64'(bus.start_wid_o), 64'd1);
    @(posedge clk);
    #1;
    bus.ib_all_instr_finished_i = 8'h00;
    stop_mask            = 8'h00;
    bus.start_valid_i    = 1'b1;
    bus.start_pc_i       = 32'h900;
    bus.start_act_mask_i = 32'h1234_5678;
    push_grant(1, 32'h900, 32'h1234_5678);
    tick(1);
    bus.start_valid_i = 1'b0;
    tick(1);
    bus.fe_ready_i = 1'b0;
    tick(2);
    check_eq("restart_granted", 64'(exp_q.size()), 64'd0);

    // Warps 5 and 6 stop and finish together: lowest index retires first.
    bus.ib_space_available_i = 8'h60;
    stop_mask = 8'h60;
    push_grant(5, 32'h620, mask_of(5));
    push_grant(6, 32'h720, mask_of(6));
    bus.fe_ready_i = 1'b1;
    tick(2);
    bus.fe_ready_i = 1'b0;
    tick(3);
    bus.ib_all_instr_finished_i = 8'h60;
    exp_done.push_back(3'd5);
    exp_done.push_back(3'd6);
    tick(4);
    check_eq("dual_retire_done", 64'(exp_done.size()), 64'd0);
    bus.ib_all_instr_finished_i = 8'h00;

    // Traffic in flight, then an asynchronous reset pulse between edges.
    chk_grants               = 1'b0;
    stop_mask                = 8'h01;
    bus.ib_space_available_i = 8'hFF;
    bus.fe_ready_i           = 1'b1;
    bus.start_valid_i        = 1'b1;
    bus.start_pc_i           = 32'hA00;
    bus.start_act_mask_i     = 32'hFFFF_FFFF;
    tick(3);
    #1 rst_n = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    bus.start_valid_i = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check_eq("post_rst_fe_valid",  64'(bus.fe_valid_o), 64'd0);
      check_eq("post_rst_done",      64'(bus.warp_done_o), 64'd0);
      check_eq("post_rst_start_wid", 64'(bus.start_wid_o), 64'd0);
    end
    check_eq("grants_left", 64'(exp_q.size()), 64'd0);
    check_eq("dones_left",  64'(exp_done.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
